// File: rtl/hoeraa_arb2.sv
// Purpose : two-requester round-robin arbiter sharing one 12-bit approximate adder,
//           with results queued in a 2-entry FIFO.
// Latency : 1 cycle from grant (rdyN) to ov; backpressure via ordy, rdyN drop when FIFO full and ordy=0.
// Config  : define HOERAA_ARB_EXACT_EN for an exact 13-bit sum instead of the approximate adder.
module hoeraa_arb2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        v0,
    input  logic [11:0] a0,
    input  logic [11:0] b0,
    input  logic        v1,
    input  logic [11:0] a1,
    input  logic [11:0] b1,
    output logic        rdy0,
    output logic        rdy1,
    output logic        ov,
    input  logic        ordy,
    output logic [12:0] osum,
    output logic        oid
);

    logic [1:0]        count_q, count_d;
    logic              ptr_q, ptr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [1:0][12:0]  mem_sum_q, mem_sum_d;
    logic [1:0]        mem_id_q, mem_id_d;

    logic              space;
    logic              gnt;
    logic              gnt_id;
    logic              push;
    logic              pop;
    logic [11:0]       op_a;
    logic [11:0]       op_b;
    logic [12:0]       sum;

    // Arbitration: grant only with room; ptr breaks ties, single requester wins outright.
    always_comb begin
        space  = (count_q < 2'd2) | ordy;
        gnt    = space & (v0 | v1) & ~rst;
        gnt_id = (v0 & v1) ? ptr_q : v1;
        rdy0   = gnt & ~gnt_id;
        rdy1   = gnt & gnt_id;
        push   = gnt;
        pop    = (count_q != 2'd0) & ordy;
        op_a   = gnt_id ? a1 : a0;
        op_b   = gnt_id ? b1 : b0;
    end

`ifdef HOERAA_ARB_EXACT_EN
    // Exact adder: full 13-bit sum of the granted operands.
    always_comb begin
        sum = {1'b0, op_a} + {1'b0, op_b};
    end
`else
    logic [5:0] sum_hi;
    // Low five bits are never computed, so they do not feed the datapath.
    logic       unused_lo;
    assign unused_lo = ^{op_a[4:0], op_b[4:0]};

    // Approximate adder: low bits forced high, bits 5/6 cheap OR/XOR guesses,
    // upper slice exact with a carry-in taken only from bit 6.
    always_comb begin
        sum_hi = {1'b0, op_a[11:7]} + {1'b0, op_b[11:7]} + {5'd0, op_a[6] & op_b[6]};
        sum    = {sum_hi,
                  (op_a[6] ^ op_b[6]) | (op_a[5] & op_b[5] & op_a[6] & op_b[6]),
                  op_a[5] | op_b[5],
                  5'b11111};
    end
`endif

    // Next-state for FIFO storage, pointers, occupancy and round-robin pointer.
    always_comb begin
        mem_sum_d = mem_sum_q;
        mem_id_d  = mem_id_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        count_d   = count_q;
        ptr_d     = ptr_q;
        if (push) begin
            mem_sum_d[wr_q] = sum;
            mem_id_d[wr_q]  = gnt_id;
            wr_d            = ~wr_q;
            ptr_d           = ~gnt_id;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset clears everything including stored results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= 2'd0;
            ptr_q     <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            mem_sum_q <= '0;
            mem_id_q  <= '0;
        end else begin
            count_q   <= count_d;
            ptr_q     <= ptr_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            mem_sum_q <= mem_sum_d;
            mem_id_q  <= mem_id_d;
        end
    end

    // Head of FIFO drives the result port directly from storage.
    always_comb begin
        ov   = (count_q != 2'd0);
        osum = mem_sum_q[rd_q];
        oid  = mem_id_q[rd_q];
    end

endmodule

// File: tb/tb_hoeraa_arb2.sv
// Directed bench for hoeraa_arb2: reset, contention, adder values, backpressure, reset mid-stream.
module tb_hoeraa_arb2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [11:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        rdy0, rdy1, ov, oid;
    logic        ordy = 1'b0;
    logic [12:0] osum;

    int checks = 0;
    int errors = 0;

`ifdef HOERAA_ARB_EXACT_EN
    localparam logic [12:0] SUM_FF_01 = 13'h0100;
    localparam logic [12:0] SUM_60    = 13'h00C0;
    localparam logic [12:0] SUM_FFF   = 13'h1FFE;
    localparam logic [12:0] SUM_ZERO  = 13'h0000;
`else
    localparam logic [12:0] SUM_FF_01 = 13'h00FF;
    localparam logic [12:0] SUM_60    = 13'h00FF;
    localparam logic [12:0] SUM_FFF   = 13'h1FFF;
    localparam logic [12:0] SUM_ZERO  = 13'h001F;
`endif

    hoeraa_arb2 dut (
        .clk (clk), .rst (rst),
        .v0  (v0),  .a0  (a0), .b0 (b0),
        .v1  (v1),  .a1  (a1), .b1 (b1),
        .rdy0(rdy0), .rdy1(rdy1),
        .ov  (ov),  .ordy(ordy), .osum(osum), .oid(oid)
    );

    always #5 clk = ~clk;

    task test_reset;
        @(negedge clk);
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; ordy = 1'b1;
        #1;
        checks++; if (ov !== 1'b0)      begin errors++; $display("FAIL reset_ov got %0b want 0", ov); end
        checks++; if (osum !== 13'h0)   begin errors++; $display("FAIL reset_osum got %h want 0000", osum); end
        checks++; if (oid !== 1'b0)     begin errors++; $display("FAIL reset_oid got %0b want 0", oid); end
        checks++; if (rdy0 !== 1'b0)    begin errors++; $display("FAIL reset_rdy0 got %0b want 0", rdy0); end
        checks++; if (rdy1 !== 1'b0)    begin errors++; $display("FAIL reset_rdy1 got %0b want 0", rdy1); end
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0; rst = 1'b0;
    endtask

    task test_contention;
        @(negedge clk);
        a0 = 12'h060; b0 = 12'h060; a1 = 12'h000; b1 = 12'h000;
        v0 = 1'b1; v1 = 1'b1; ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (rdy0 !== ~i[0]) begin errors++; $display("FAIL cont_rdy0[%0d] got %0b want %0b", i, rdy0, ~i[0]); end
            checks++; if (rdy1 !== i[0])  begin errors++; $display("FAIL cont_rdy1[%0d] got %0b want %0b", i, rdy1, i[0]); end
            if (i > 0) begin
                checks++; if (ov !== 1'b1)   begin errors++; $display("FAIL cont_ov[%0d] got %0b want 1", i, ov); end
                checks++; if (oid !== ~i[0]) begin errors++; $display("FAIL cont_oid[%0d] got %0b want %0b", i, oid, ~i[0]); end
            end
            @(negedge clk);
        end
        v0 = 1'b0; v1 = 1'b0;
        #1;
        checks++; if (oid !== 1'b1)     begin errors++; $display("FAIL cont_last_oid got %0b want 1", oid); end
        checks++; if (osum !== SUM_ZERO) begin errors++; $display("FAIL cont_last_osum got %h want %h", osum, SUM_ZERO); end
        @(negedge clk);
        #1;
        checks++; if (ov !== 1'b0)      begin errors++; $display("FAIL cont_drain_ov got %0b want 0", ov); end
    endtask

    task test_approx;
        @(negedge clk);
        ordy = 1'b1; v0 = 1'b1; a0 = 12'h0FF; b0 = 12'h001;
        #1;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL approx_rdy0 got %0b want 1", rdy0); end
        checks++; if (ov !== 1'b0)   begin errors++; $display("FAIL approx_ov_pre got %0b want 0", ov); end
        @(negedge clk);
        v0 = 1'b0;
        #1;
        checks++; if (ov !== 1'b1)        begin errors++; $display("FAIL approx_ov got %0b want 1", ov); end
        checks++; if (oid !== 1'b0)       begin errors++; $display("FAIL approx_oid got %0b want 0", oid); end
        checks++; if (osum !== SUM_FF_01) begin errors++; $display("FAIL approx_osum got %h want %h", osum, SUM_FF_01); end
        @(negedge clk);
        #1;
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL approx_pop_ov got %0b want 0", ov); end
    endtask

    task test_carry;
        @(negedge clk);
        ordy = 1'b1; v1 = 1'b1; a1 = 12'h060; b1 = 12'h060;
        #1;
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL carry_rdy1 got %0b want 1", rdy1); end
        @(negedge clk);
        v1 = 1'b0; v0 = 1'b1; a0 = 12'hFFF; b0 = 12'hFFF;
        #1;
        checks++; if (rdy0 !== 1'b1)   begin errors++; $display("FAIL carry_rdy0 got %0b want 1", rdy0); end
        checks++; if (osum !== SUM_60) begin errors++; $display("FAIL carry_060_osum got %h want %h", osum, SUM_60); end
        checks++; if (oid !== 1'b1)    begin errors++; $display("FAIL carry_060_oid got %0b want 1", oid); end
        @(negedge clk);
        v0 = 1'b0;
        #1;
        checks++; if (osum !== SUM_FFF) begin errors++; $display("FAIL carry_fff_osum got %h want %h", osum, SUM_FFF); end
        checks++; if (oid !== 1'b0)     begin errors++; $display("FAIL carry_fff_oid got %0b want 0", oid); end
        @(negedge clk);
    endtask

    task test_backpressure;
        @(negedge clk);
        ordy = 1'b0; v0 = 1'b1; a0 = 12'h060; b0 = 12'h060;
        #1;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL bp_rdy0_first got %0b want 1", rdy0); end
        @(negedge clk);
        a0 = 12'h000; b0 = 12'h000;
        #1;
        checks++; if (rdy0 !== 1'b1)   begin errors++; $display("FAIL bp_rdy0_second got %0b want 1", rdy0); end
        checks++; if (osum !== SUM_60) begin errors++; $display("FAIL bp_head1 got %h want %h", osum, SUM_60); end
        @(negedge clk);
        a0 = 12'hFFF; b0 = 12'hFFF;
        #1;
        checks++; if (rdy0 !== 1'b0)   begin errors++; $display("FAIL bp_full_rdy0 got %0b want 0", rdy0); end
        checks++; if (osum !== SUM_60) begin errors++; $display("FAIL bp_full_osum got %h want %h", osum, SUM_60); end
        @(negedge clk);
        v1 = 1'b1;
        #1;
        checks++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin errors++; $display("FAIL bp_full_rdy got %0b%0b want 00", rdy1, rdy0); end
        checks++; if (osum !== SUM_60 || oid !== 1'b0) begin errors++; $display("FAIL bp_stable got %h/%0b want %h/0", osum, oid, SUM_60); end
        v1 = 1'b0; ordy = 1'b1;
        #1;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL bp_pushpop_rdy0 got %0b want 1", rdy0); end
        @(negedge clk);
        v0 = 1'b0;
        #1;
        checks++; if (ov !== 1'b1)       begin errors++; $display("FAIL bp_order2_ov got %0b want 1", ov); end
        checks++; if (osum !== SUM_ZERO) begin errors++; $display("FAIL bp_order2_osum got %h want %h", osum, SUM_ZERO); end
        @(negedge clk);
        #1;
        checks++; if (osum !== SUM_FFF) begin errors++; $display("FAIL bp_order3_osum got %h want %h", osum, SUM_FFF); end
        @(negedge clk);
        #1;
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL bp_drain_ov got %0b want 0", ov); end
    endtask

    task test_reset_mid;
        @(negedge clk);
        ordy = 1'b0; v0 = 1'b1; a0 = 12'h060; b0 = 12'h060;
        @(negedge clk);
        @(negedge clk);
        v0 = 1'b0;
        #1;
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL mid_pre_ov got %0b want 1", ov); end
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1;
        #1;
        checks++; if (ov !== 1'b0)      begin errors++; $display("FAIL mid_rst_ov got %0b want 0", ov); end
        checks++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin errors++; $display("FAIL mid_rst_rdy got %0b%0b want 00", rdy1, rdy0); end
        checks++; if (osum !== 13'h0)   begin errors++; $display("FAIL mid_rst_osum got %h want 0000", osum); end
        @(negedge clk);
        rst = 1'b0; ordy = 1'b1;
        #1;
        checks++; if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin errors++; $display("FAIL mid_first_grant got %0b%0b want 01", rdy1, rdy0); end
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        #1;
        checks++; if (ov !== 1'b1 || oid !== 1'b0) begin errors++; $display("FAIL mid_first_result got %0b/%0b want 1/0", ov, oid); end
        checks++; if (osum !== SUM_60) begin errors++; $display("FAIL mid_first_osum got %h want %h", osum, SUM_60); end
        @(negedge clk);
        #1;
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mid_drain_ov got %0b want 0", ov); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_approx();
        test_carry();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
